multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_i.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 instr_i  input  32  instruction word from instruction memory; valid when mem_ready_i=1 in IF.
REQ-005 mem_ready_i  input  1  memory completion strobe for the current request.
REQ-006 zero_i  input  1  ALU zero flag; sampled in EX.
REQ-007 mem_req_o  output  1  memory request, held until the accepting mem_ready_i cycle.
REQ-008 mem_write_o  output  1  request is a store; 0 means read.
REQ-009 ir_write_o  output  1  latch instr_i into the datapath IR.
REQ-010 pc_write_o  output  1  load PC from next-PC mux.
REQ-011 pc_sel_o  output  1  0 = PC+4, 1 = branch/jump target.
REQ-012 reg_write_o  output  1  register-file write enable.
REQ-013 alu_src_o  output  1  0 = rs2, 1 = immediate.
REQ-014 alu_op_o  output  2  00 add, 01 sub/compare, 10 funct-decoded.
REQ-015 state_o  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-016 retire_cnt_o  output  16  count of retired instructions.

Function
REQ-017 Moore FSM; every output SHALL be a function of state and the latched opcode only, except pc_sel_o, which also uses the zero flag latched in EX.
REQ-018 IF: mem_req_o=1, mem_write_o=0; on mem_ready_i=1, assert ir_write_o and pc_write_o with pc_sel_o=0 in that cycle, latch instr_i[6:0] as opcode_q, go to ID; otherwise stay in IF with outputs unchanged.
REQ-019 ID: no enables; next state is EX for opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1101111.
REQ-020 Any other opcode in ID SHALL go to IF, increment retire_cnt_o and assert no write enable (treated as NOP).
REQ-021 EX alu_op_o / alu_src_o:
- R-type: 10 / 0.
- I-ALU: 10 / 1.
- load/store: 00 / 1.
- branch: 01 / 0.
- JAL: 00 / 1.
REQ-022 EX next state:
- R-type, I-ALU, JAL: WB.
- load/store: MEM.
- branch: IF.
REQ-023 Branch in EX SHALL latch zero_i; if zero_i=1, assert pc_write_o with pc_sel_o=1 in that cycle; the branch retires in EX.
REQ-024 MEM: mem_req_o=1, mem_write_o=1 for a store and 0 for a load; hold until mem_ready_i=1, then go to WB (load) or IF (store, retires).
REQ-025 WB: reg_write_o=1 for exactly one cycle, then go to IF. JAL SHALL also assert pc_write_o with pc_sel_o=1 in WB.
REQ-026 retire_cnt_o SHALL increment by 1 in the cycle an instruction leaves its last state (WB, store MEM, branch EX, NOP ID), and wrap from 0xFFFF to 0x0000.
REQ-027 mem_ready_i SHALL be ignored in ID, EX and WB.
REQ-028 reg_write_o and mem_write_o SHALL never both be 1 in the same cycle.
REQ-029 Latency in cycles with zero-wait memory: R/I/JAL 4, load 5, store 4, branch 3, NOP 2. Each memory wait cycle SHALL add exactly one cycle.

Reset
REQ-030 While rst_i=0, state SHALL be IF and all of the following SHALL be 0: outputs, opcode_q, the latched zero flag and retire_cnt_o.
REQ-031 In IF after reset, mem_req_o SHALL be 1 from the first clock edge after rst_i deasserts.
REQ-032 Reset asserted in any state, including mid-memory-wait, SHALL abort the instruction with no further write enables and no counter increment.

Verification
REQ-033 R-type add (0x002081B3), mem_ready_i=1 always -> states 0,1,2,4,0; reg_write_o=1 only in WB; retire_cnt_o=1.
REQ-034 Load (0x0000A103), mem_ready_i low for 2 cycles in IF and 3 in MEM -> 10-cycle instruction; mem_req_o held throughout each wait; reg_write_o pulses once.
REQ-035 Branch beq with zero_i=1, then with zero_i=0 -> pc_write_o with pc_sel_o=1 in EX for the first only; 3 cycles each; no reg_write_o.
REQ-036 Store followed by an illegal opcode 0x0000007F -> store asserts mem_write_o in MEM and no reg_write_o; illegal returns to IF from ID; retire_cnt_o=2.
REQ-037 Preload retire_cnt_o to 0xFFFF via 65535 NOPs, then retire one more -> 0x0000.
REQ-038 rst_i pulsed low during MEM wait -> immediate IF, all outputs 0, counter 0; next fetch after release is normal.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a five-state multicycle RISC-V-style core (IF, ID, EX, MEM,
// WB). It sequences instruction fetch, decode, execute, data memory access and
// write-back. It also counts retired instructions.
//
// Ports
//   clk_i          rising-edge clock for all state
//   rst_i          asynchronous active-low reset
//   instr_i        instruction word; sampled in IF when mem_ready_i=1
//   mem_ready_i    completion strobe for the outstanding memory request
//   zero_i         ALU zero flag; used by branches in EX
//   mem_req_o      memory request, held until the accepting mem_ready_i cycle
//   mem_write_o    request is a store (0 = read)
//   ir_write_o     latch instr_i into the datapath IR
//   pc_write_o     load PC from the next-PC mux
//   pc_sel_o       next-PC select: 0 = PC+4, 1 = branch/jump target
//   reg_write_o    register-file write enable
//   alu_src_o      ALU operand B: 0 = rs2, 1 = immediate
//   alu_op_o       00 add, 01 sub/compare, 10 funct-decoded
//   state_o        current state: IF=0, ID=1, EX=2, MEM=3, WB=4
//   retire_cnt_o   retired-instruction counter (wraps at 16 bits)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_sel_o,
  output logic        reg_write_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic [2:0]  state_o,
  output logic [15:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  state_e      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic        zero_q, zero_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic        retire;

  // run_q holds outputs quiet until the first clock edge after reset release.
  // The fetch request therefore appears on that edge, not on the deasserting
  // edge of rst_i.
  logic        run_q;

  // Opcode class decode of the latched opcode.
  logic is_rtype, is_ialu, is_load, is_store, is_branch, is_jal, is_legal;

  always_comb begin
    is_rtype  = (opcode_q == OpRType);
    is_ialu   = (opcode_q == OpIAlu);
    is_load   = (opcode_q == OpLoad);
    is_store  = (opcode_q == OpStore);
    is_branch = (opcode_q == OpBranch);
    is_jal    = (opcode_q == OpJal);
    is_legal  = is_rtype | is_ialu | is_load | is_store | is_branch | is_jal;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIf;
      opcode_q     <= 7'd0;
      zero_q       <= 1'b0;
      retire_cnt_q <= 16'd0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      zero_q       <= zero_d;
      retire_cnt_q <= retire_cnt_d;
      run_q        <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    zero_d      = zero_q;
    retire      = 1'b0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_sel_o    = 1'b0;
    reg_write_o = 1'b0;
    alu_src_o   = 1'b0;
    alu_op_o    = AluAdd;

    unique case (state_q)
      StIf: begin
        mem_req_o = run_q;
        if (run_q && mem_ready_i) begin
          // Fetch accepted: capture IR and advance PC to PC+4 together.
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          opcode_d   = instr_i[6:0];
          state_d    = StId;
        end
      end

      StId: begin
        if (is_legal) begin
          state_d = StEx;
        end else begin
          // Unknown opcode: retire as a NOP without touching any state.
          retire  = 1'b1;
          state_d = StIf;
        end
      end

      StEx: begin
        if (is_rtype) begin
          alu_op_o  = AluFunct;
          alu_src_o = 1'b0;
          state_d   = StWb;
        end else if (is_ialu) begin
          alu_op_o  = AluFunct;
          alu_src_o = 1'b1;
          state_d   = StWb;
        end else if (is_load || is_store) begin
          alu_op_o  = AluAdd;
          alu_src_o = 1'b1;
          state_d   = StMem;
        end else if (is_branch) begin
          // Compare happens this cycle, so the taken decision uses the live
          // zero flag; the flag is also captured for the rest of the core.
          alu_op_o   = AluSub;
          alu_src_o  = 1'b0;
          zero_d     = zero_i;
          pc_write_o = zero_i;
          pc_sel_o   = zero_i;
          retire     = 1'b1;
          state_d    = StIf;
        end else if (is_jal) begin
          alu_op_o  = AluAdd;
          alu_src_o = 1'b1;
          state_d   = StWb;
        end else begin
          state_d = StIf;
        end
      end

      StMem: begin
        mem_req_o   = 1'b1;
        mem_write_o = is_store;
        if (mem_ready_i) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = StIf;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        reg_write_o = 1'b1;
        pc_write_o  = is_jal;
        pc_sel_o    = is_jal;
        retire      = 1'b1;
        state_d     = StIf;
      end

      default: begin
        state_d = StIf;
      end
    endcase
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  assign state_o      = state_q;
  assign retire_cnt_o = retire_cnt_q;

  // Upper instruction bits belong to the datapath; the latched zero flag is
  // kept for the datapath and is not needed by the sequencing itself.
  logic unused_sigs;
  assign unused_sigs = ^{instr_i[31:7], zero_q};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench for multicycle_ctrl. Each issued instruction is expanded by
// a behavioural model into its per-cycle expected observation. The model goes
// phase by phase: fetch waits, decode, execute, memory waits and write-back.
// The expected observations are queued. A negedge monitor pops one entry per
// cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        mem_ready_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        mem_req_o, mem_write_o, ir_write_o, pc_write_o, pc_sel_o;
  logic        reg_write_o, alu_src_o;
  logic [1:0]  alu_op_o;
  logic [2:0]  state_o;
  logic [15:0] retire_cnt_o;

  multicycle_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .mem_ready_i  (mem_ready_i),
    .zero_i       (zero_i),
    .mem_req_o    (mem_req_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_sel_o     (pc_sel_o),
    .reg_write_o  (reg_write_o),
    .alu_src_o    (alu_src_o),
    .alu_op_o     (alu_op_o),
    .state_o      (state_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_sel;
    logic        reg_write;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    bit         legal;
    bit         mem;
    bit         store;
    bit         wb;
    bit         jal;
    bit         br;
    logic [1:0] aop;
    logic       asrc;
  } kind_t;

  obs_t        exp_q[$];
  logic        stim_rdy[$];
  logic        stim_zr[$];
  logic [31:0] stim_in[$];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_cnt = 16'd0;

  obs_t mon_exp, mon_act;

  function automatic obs_t sample();
    obs_t o;
    o.state     = state_o;
    o.mem_req   = mem_req_o;
    o.mem_write = mem_write_o;
    o.ir_write  = ir_write_o;
    o.pc_write  = pc_write_o;
    o.pc_sel    = pc_sel_o;
    o.reg_write = reg_write_o;
    o.alu_src   = alu_src_o;
    o.alu_op    = alu_op_o;
    o.cnt       = retire_cnt_o;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d req=%b mw=%b ir=%b pcw=%b pcs=%b rw=%b src=%b op=%b cnt=%h",
                     o.state, o.mem_req, o.mem_write, o.ir_write, o.pc_write, o.pc_sel,
                     o.reg_write, o.alu_src, o.alu_op, o.cnt);
  endfunction

  // Instruction classes and their EX controls as listed in the control table.
  function automatic kind_t classify(input logic [6:0] op);
    kind_t k;
    k = '0;
    case (op)
      7'b0110011: begin k.legal = 1; k.wb = 1; k.aop = 2'b10; k.asrc = 0; end
      7'b0010011: begin k.legal = 1; k.wb = 1; k.aop = 2'b10; k.asrc = 1; end
      7'b0000011: begin k.legal = 1; k.mem = 1; k.wb = 1; k.aop = 2'b00; k.asrc = 1; end
      7'b0100011: begin k.legal = 1; k.mem = 1; k.store = 1; k.aop = 2'b00; k.asrc = 1; end
      7'b1100011: begin k.legal = 1; k.br = 1; k.aop = 2'b01; k.asrc = 0; end
      7'b1101111: begin k.legal = 1; k.wb = 1; k.jal = 1; k.aop = 2'b00; k.asrc = 1; end
      default:    k.legal = 0;
    endcase
    return k;
  endfunction

  // Monitor: one expected observation per clock while the scoreboard is fed.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = sample();
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL cycle_obs @%0t got {%s} expected {%s}", $time, fmt(mon_act),
                 fmt(mon_exp));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {4'd0, state_o, mem_req_o, mem_write_o, ir_write_o, pc_write_o, pc_sel_o,
            reg_write_o, alu_src_o, alu_op_o, retire_cnt_o};
  endfunction

  task automatic push_cyc(input obs_t o, input logic rdy, input logic zr, input logic [31:0] w);
    exp_q.push_back(o);
    stim_rdy.push_back(rdy);
    stim_zr.push_back(zr);
    stim_in.push_back(w);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Expand one instruction into expected per-cycle observations, then drive it.
  // With abort_mem set, stimulus stops inside the memory wait and the
  // instruction does not retire.
  task automatic issue(input logic [31:0] word, input int wif, input int wmem, input logic z,
                       input bit abort_mem);
    kind_t k;
    obs_t  base, o;
    k = classify(word[6:0]);
    base = '0;
    base.cnt = model_cnt;
    for (int i = 0; i < wif; i++) begin
      o = base; o.state = 3'd0; o.mem_req = 1'b1;
      push_cyc(o, 1'b0, rnd(), $urandom);
    end
    o = base; o.state = 3'd0; o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push_cyc(o, 1'b1, rnd(), word);
    o = base; o.state = 3'd1;
    push_cyc(o, rnd(), rnd(), $urandom);
    if (k.legal) begin
      o = base; o.state = 3'd2; o.alu_op = k.aop; o.alu_src = k.asrc;
      if (k.br) begin
        o.pc_write = z;
        o.pc_sel   = z;
      end
      push_cyc(o, rnd(), k.br ? z : rnd(), $urandom);
      if (k.mem) begin
        o = base; o.state = 3'd3; o.mem_req = 1'b1; o.mem_write = k.store;
        for (int i = 0; i < wmem; i++) push_cyc(o, 1'b0, rnd(), $urandom);
        if (!abort_mem) push_cyc(o, 1'b1, rnd(), $urandom);
      end
      if (k.wb && !abort_mem) begin
        o = base; o.state = 3'd4; o.reg_write = 1'b1; o.pc_write = k.jal; o.pc_sel = k.jal;
        push_cyc(o, rnd(), rnd(), $urandom);
      end
    end
    if (!abort_mem) model_cnt = model_cnt + 16'd1;
    while (stim_rdy.size() > 0) begin
      mem_ready_i = stim_rdy.pop_front();
      zero_i      = stim_zr.pop_front();
      instr_i     = stim_in.pop_front();
      @(posedge clk_i);
      #1;
    end
  endtask

  // Reset, check quiet outputs, release, and stop 1 time unit after the first
  // active edge. mem_ready_i is held high to show it is ignored before that edge.
  task automatic do_reset();
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    instr_i     = 32'h002081B3;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", all_outs(), 32'd0);
    rst_i = 1'b1;
    #1;
    check("pre_edge_mem_req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    model_cnt = 16'd0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [7];
    logic [6:0] op;
    int sel;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    sel = $urandom_range(0, 6);
    if (sel < 6) begin
      op = ops[sel];
    end else begin
      op = 7'($urandom);
      while (classify(op).legal) op = 7'($urandom);
    end
    return {25'($urandom), op};
  endfunction

  localparam logic [31:0] InstrAdd   = 32'h002081B3;
  localparam logic [31:0] InstrLoad  = 32'h0000A103;
  localparam logic [31:0] InstrBeq   = 32'h00208063;
  localparam logic [31:0] InstrStore = 32'h0020A023;
  localparam logic [31:0] InstrBad   = 32'h0000007F;

  initial begin
    do_reset();

    // R-type add, zero-wait memory.
    issue(InstrAdd, 0, 0, 1'b0, 1'b0);
    check("rtype_retire_cnt", {16'd0, retire_cnt_o}, 32'd1);

    // Load with 2 fetch waits and 3 data waits.
    issue(InstrLoad, 2, 3, 1'b0, 1'b0);

    // Branch taken, then not taken.
    issue(InstrBeq, 0, 0, 1'b1, 1'b0);
    issue(InstrBeq, 0, 0, 1'b0, 1'b0);
    check("after_branches_cnt", {16'd0, retire_cnt_o}, 32'd4);

    // Store then illegal opcode from a clean counter.
    do_reset();
    issue(InstrStore, 0, 1, 1'b0, 1'b0);
    issue(InstrBad, 1, 0, 1'b0, 1'b0);
    check("store_illegal_cnt", {16'd0, retire_cnt_o}, 32'd2);

    // Randomized mix of classes, wait states and zero flags.
    for (int n = 0; n < 200; n++) begin
      issue(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rnd(), 1'b0);
    end
    check("random_cnt", {16'd0, retire_cnt_o}, {16'd0, model_cnt});

    // Reset pulse in the middle of a data-memory wait.
    issue(InstrLoad, 1, 2, 1'b0, 1'b1);
    check("abort_in_mem_state", {29'd0, state_o}, 32'd3);
    mem_ready_i = 1'b0;
    rst_i       = 1'b0;
    #1;
    check("abort_outputs", all_outs(), 32'd0);
    do_reset();
    issue(InstrAdd, 0, 0, 1'b0, 1'b0);
    check("post_abort_cnt", {16'd0, retire_cnt_o}, 32'd1);

    // Counter wrap: 65535 zero-wait NOPs, then one more.
    do_reset();
    mem_ready_i = 1'b1;
    instr_i     = 32'd0;
    repeat (2 * 65535) @(posedge clk_i);
    #1;
    check("preload_cnt", {16'd0, retire_cnt_o}, 32'h0000FFFF);
    model_cnt = 16'hFFFF;
    issue(InstrBad, 0, 0, 1'b0, 1'b0);
    check("wrap_cnt", {16'd0, retire_cnt_o}, 32'd0);

    @(negedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
